// File: rtl/dodge_pkg.sv
// Shared definitions for the falling-obstacle game stage.
// Contents:
//   state_t      - obstacle controller states
//   LFSR_SEED    - value the spawn-column LFSR loads on reset
//   LFSR_TAPS    - Fibonacci tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   DODGE_CNT_W  - width of the saturating dodge counter
//   lfsr_advance - one shift of the 8-bit Fibonacci LFSR
package dodge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPAWN_WAIT,
    FALL,
    HIT_HOLD
  } state_t;

  localparam logic [7:0] LFSR_SEED   = 8'hA5;
  localparam logic [7:0] LFSR_TAPS   = 8'hB8;
  localparam int         DODGE_CNT_W = 8;

  // Shift left and feed the XOR of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_advance(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Turns a slow level signal from a clock divider into a one-CLK step pulse
// on each of its rising edges. The level is only ever sampled, never used
// as a clock, so any divider stage can feed this.
// Ports:
//   CLK     - system clock
//   RST_N   - synchronous active-low reset, clears both history flops
//   TICK_IN - divided-clock level
//   STEP    - high for exactly one CLK after a 0->1 transition of TICK_IN
module tick_edge_detect (
  input  logic CLK,
  input  logic RST_N,
  input  logic TICK_IN,
  output logic STEP
);

  logic tick_new;
  logic tick_old;

  // Two-deep history of the sampled level; tick_new is the most recent sample.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tick_new <= 1'b0;
      tick_old <= 1'b0;
    end else begin
      tick_new <= TICK_IN;
      tick_old <= tick_new;
    end
  end

  assign STEP = tick_new & ~tick_old;

endmodule

// File: rtl/falling_obstacle_ctrl.sv
// Single falling obstacle for the LED-matrix game. Each rising edge of the
// divided fall tick advances the obstacle one step: a few steps of waiting,
// a spawn at a pseudo-random column, one row per step, then a hit or dodge
// judgement against the player column on the bottom row.
// Optional feature macro: DODGE_SPEEDUP_EN. When defined, once DODGE_CNT
// reaches SPEEDUP_AT the obstacle spawns on the first step after a dodge.
// Ports:
//   CLK        - system clock
//   RST_N      - synchronous active-low reset
//   TICK_IN    - divided-clock level, one step per rising edge
//   GAME_RUN   - 1 while the game is active; 0 aborts back to IDLE
//   PLAYER_COL - player column, judged only on the bottom-row step
//   OBJ_ROW    - obstacle row (0 at top)
//   OBJ_COL    - obstacle column
//   OBJ_VALID  - obstacle visible on the matrix
//   HIT        - one-cycle pulse when the obstacle lands on the player
//   DODGE      - one-cycle pulse when the obstacle passes the player
//   DODGE_CNT  - saturating count of dodges since the game started
module falling_obstacle_ctrl
  import dodge_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int SPAWN_DELAY = 2
`ifdef DODGE_SPEEDUP_EN
  ,
  parameter int SPEEDUP_AT  = 16
`endif
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     TICK_IN,
  input  logic                     GAME_RUN,
  input  logic [$clog2(COLS)-1:0]  PLAYER_COL,
  output logic [$clog2(ROWS)-1:0]  OBJ_ROW,
  output logic [$clog2(COLS)-1:0]  OBJ_COL,
  output logic                     OBJ_VALID,
  output logic                     HIT,
  output logic                     DODGE,
  output logic [DODGE_CNT_W-1:0]   DODGE_CNT
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int WAIT_W = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(SPAWN_DELAY - 1);

  state_t                 state;
  state_t                 state_d;
  logic [7:0]             lfsr;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [WAIT_W-1:0]      wait_d;
  logic [ROW_W-1:0]       row_d;
  logic [COL_W-1:0]       col_d;
  logic                   valid_d;
  logic                   hit_d;
  logic                   dodge_d;
  logic [DODGE_CNT_W-1:0] cnt_d;
  logic                   step;
  logic                   spawn_now;

  tick_edge_detect u_tick (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .TICK_IN (TICK_IN),
    .STEP    (step)
  );

  // Whether the current SPAWN_WAIT step is the one that releases the obstacle.
`ifdef DODGE_SPEEDUP_EN
  assign spawn_now = (wait_cnt == LAST_WAIT) ||
                     (DODGE_CNT >= DODGE_CNT_W'(SPEEDUP_AT));
`else
  assign spawn_now = (wait_cnt == LAST_WAIT);
`endif

  // Next-state and next-output logic. Dropping GAME_RUN outranks any
  // coincident step, so an abort on the bottom row never scores.
  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    row_d   = OBJ_ROW;
    col_d   = OBJ_COL;
    valid_d = OBJ_VALID;
    hit_d   = 1'b0;
    dodge_d = 1'b0;
    cnt_d   = DODGE_CNT;

    if (state != IDLE && !GAME_RUN) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_d = 1'b0;
          if (GAME_RUN) begin
            state_d = SPAWN_WAIT;
            wait_d  = '0;
            cnt_d   = '0;
          end
        end
        SPAWN_WAIT: begin
          valid_d = 1'b0;
          if (step) begin
            if (spawn_now) begin
              col_d   = lfsr[COL_W-1:0];
              row_d   = '0;
              valid_d = 1'b1;
              state_d = FALL;
            end else begin
              wait_d = wait_cnt + 1'b1;
            end
          end
        end
        FALL: begin
          if (step) begin
            if (OBJ_ROW < LAST_ROW) begin
              row_d = OBJ_ROW + 1'b1;
            end else if (OBJ_COL == PLAYER_COL) begin
              hit_d   = 1'b1;
              state_d = HIT_HOLD;
            end else begin
              dodge_d = 1'b1;
              if (DODGE_CNT != '1) begin
                cnt_d = DODGE_CNT + 1'b1;
              end
              valid_d = 1'b0;
              wait_d  = '0;
              state_d = SPAWN_WAIT;
            end
          end
        end
        HIT_HOLD: begin
          valid_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. The LFSR free-runs every cycle so the spawn
  // column depends on when the player reached the spawn, not just the count.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      OBJ_ROW   <= '0;
      OBJ_COL   <= '0;
      OBJ_VALID <= 1'b0;
      HIT       <= 1'b0;
      DODGE     <= 1'b0;
      DODGE_CNT <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_d;
      OBJ_ROW   <= row_d;
      OBJ_COL   <= col_d;
      OBJ_VALID <= valid_d;
      HIT       <= hit_d;
      DODGE     <= dodge_d;
      DODGE_CNT <= cnt_d;
      lfsr      <= lfsr_advance(lfsr);
    end
  end

endmodule

// File: tb/tb_falling_obstacle_ctrl.sv
// Self-checking bench for falling_obstacle_ctrl. A round-based model
// (steps counted since the round began) predicts the outputs every cycle;
// directed sequences add literal expectations at key points.
// Honours DODGE_SPEEDUP_EN when the bench and RTL are built with it.
module tb_falling_obstacle_ctrl;

  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  localparam int SPAWN_DELAY = 2;
  localparam int SPEEDUP_AT  = 16;
`ifdef DODGE_SPEEDUP_EN
  localparam int SPEEDUP_EXPECT = 1;
`else
  localparam int SPEEDUP_EXPECT = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       TICK_IN;
  logic       GAME_RUN;
  logic [2:0] PLAYER_COL;
  logic [2:0] OBJ_ROW;
  logic [2:0] OBJ_COL;
  logic       OBJ_VALID;
  logic       HIT;
  logic       DODGE;
  logic [7:0] DODGE_CNT;

  int checks = 0;
  int errors = 0;

  falling_obstacle_ctrl #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .SPAWN_DELAY (SPAWN_DELAY)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .TICK_IN    (TICK_IN),
    .GAME_RUN   (GAME_RUN),
    .PLAYER_COL (PLAYER_COL),
    .OBJ_ROW    (OBJ_ROW),
    .OBJ_COL    (OBJ_COL),
    .OBJ_VALID  (OBJ_VALID),
    .HIT        (HIT),
    .DODGE      (DODGE),
    .DODGE_CNT  (DODGE_CNT)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  logic [7:0] m_lfsr;
  logic       m_t1, m_t2;
  logic       m_active, m_held;
  int         m_round_steps;
  logic [2:0] m_row, m_col;
  logic       m_valid, m_hit, m_dodge;
  int         m_cnt;
  logic       model_ready = 1'b0;

  function automatic logic [7:0] model_lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Each round: SPAWN_DELAY steps to appear (1 with the speedup active),
  // then ROWS-1 steps down to the bottom row, then one judging step.
  always @(posedge CLK) begin
    logic step_now;
    int   need;
    if (!RST_N) begin
      m_lfsr = 8'hA5; m_t1 = 1'b0; m_t2 = 1'b0;
      m_active = 1'b0; m_held = 1'b0; m_round_steps = 0;
      m_row = 3'd0; m_col = 3'd0; m_valid = 1'b0; m_hit = 1'b0; m_dodge = 1'b0;
      m_cnt = 0;
      model_ready = 1'b1;
    end else begin
      step_now = m_t1 && !m_t2;
      m_t2 = m_t1;
      m_t1 = TICK_IN;
      m_hit = 1'b0;
      m_dodge = 1'b0;
      if (!m_active) begin
        if (GAME_RUN) begin
          m_active = 1'b1; m_held = 1'b0; m_round_steps = 0; m_cnt = 0;
        end
      end else if (!GAME_RUN) begin
        m_active = 1'b0;
        m_valid = 1'b0;
      end else if (!m_held && step_now) begin
        need = SPAWN_DELAY;
`ifdef DODGE_SPEEDUP_EN
        if (m_cnt >= SPEEDUP_AT) need = 1;
`endif
        m_round_steps++;
        if (m_round_steps == need) begin
          m_col = m_lfsr[2:0];
          m_row = 3'd0;
          m_valid = 1'b1;
        end else if (m_round_steps > need && m_round_steps < need + ROWS) begin
          m_row = 3'(m_round_steps - need);
        end else if (m_round_steps == need + ROWS) begin
          if (m_col == PLAYER_COL) begin
            m_hit = 1'b1;
            m_held = 1'b1;
          end else begin
            m_dodge = 1'b1;
            if (m_cnt < 255) m_cnt++;
            m_valid = 1'b0;
            m_round_steps = 0;
          end
        end
      end
      m_lfsr = model_lfsr_step(m_lfsr);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(negedge CLK) begin
    if (model_ready) begin
      checkOutput("cyc_valid", 32'(OBJ_VALID), 32'(m_valid));
      checkOutput("cyc_row",   32'(OBJ_ROW),   32'(m_row));
      checkOutput("cyc_col",   32'(OBJ_COL),   32'(m_col));
      checkOutput("cyc_hit",   32'(HIT),       32'(m_hit));
      checkOutput("cyc_dodge", 32'(DODGE),     32'(m_dodge));
      checkOutput("cyc_cnt",   32'(DODGE_CNT), m_cnt);
      checkOutput("cyc_lfsr",  32'(dut.lfsr),  32'(m_lfsr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic rst_n, input logic tick,
                               input logic run, input logic [2:0] pcol);
    RST_N = rst_n;
    TICK_IN = tick;
    GAME_RUN = run;
    PLAYER_COL = pcol;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  // One tick pulse; returns just after the edge on which the step acts.
  task automatic do_step(input logic [2:0] pcol);
    applyStimulus(1'b1, 1'b1, 1'b1, pcol);
    next_cycle();
    applyStimulus(1'b1, 1'b0, 1'b1, pcol);
    next_cycle();
  endtask

  task automatic dodge_round(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      do_step(~m_col);
      if (m_dodge) seen = 1'b1;
    end
    if (!seen) checkOutput("dodge_round_timeout", 32'd0, 32'd1);
  endtask

  task automatic step_to_row(input logic [2:0] target, input logic [2:0] pcol);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      do_step(pcol);
      if (m_valid && m_row == target) ok = 1'b1;
    end
    if (!ok) checkOutput("step_to_row_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic       seen;
    logic       found;
    logic [7:0] ahead;

    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);

    // Reset held three cycles while TICK_IN and GAME_RUN wiggle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, ~i[0], i[0], 3'd0);
      next_cycle();
    end
    checkOutput("rst_valid", 32'(OBJ_VALID), 0);
    checkOutput("rst_row",   32'(OBJ_ROW),   0);
    checkOutput("rst_col",   32'(OBJ_COL),   0);
    checkOutput("rst_hit",   32'(HIT),       0);
    checkOutput("rst_dodge", 32'(DODGE),     0);
    checkOutput("rst_cnt",   32'(DODGE_CNT), 0);
    checkOutput("rst_lfsr",  32'(dut.lfsr),  'hA5);
    checkOutput("rst_idle",  32'(dut.state == dodge_pkg::IDLE), 1);

    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    next_cycle();
    checkOutput("lfsr_1",       32'(dut.lfsr), 'h4A);
    checkOutput("model_lfsr_1", 32'(m_lfsr),   'h4A);
    next_cycle();
    checkOutput("lfsr_2",       32'(dut.lfsr), 'h95);

    // Start the game; a TICK_IN held high for 100 cycles is a single step.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0);
    next_cycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0);
    repeat (100) next_cycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0);
    next_cycle();
    next_cycle();
    checkOutput("long_tick_one_step", 32'(OBJ_VALID), 0);

    // Line the spawn step up with an LFSR value whose low bits are 5.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      next_cycle();
      ahead = model_lfsr_step(m_lfsr);
      if (ahead[2:0] == 3'd5) found = 1'b1;
    end
    if (!found) checkOutput("col5_search_timeout", 32'd0, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0);
    next_cycle();
    checkOutput("latency_early", 32'(OBJ_VALID), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0);
    next_cycle();
    checkOutput("latency_spawn", 32'(OBJ_VALID), 1);
    checkOutput("spawn_col5",    32'(OBJ_COL),   5);
    checkOutput("spawn_row0",    32'(OBJ_ROW),   0);

    // Dodge: player at column 0 while the obstacle falls in column 5.
    for (int r = 1; r <= 7; r++) begin
      do_step(3'd0);
      checkOutput("fall_row", 32'(OBJ_ROW), r);
    end
    do_step(3'd0);
    checkOutput("dodge_pulse", 32'(DODGE),     1);
    checkOutput("dodge_nohit", 32'(HIT),       0);
    checkOutput("dodge_cnt1",  32'(DODGE_CNT), 1);
    checkOutput("dodge_gone",  32'(OBJ_VALID), 0);
    next_cycle();
    checkOutput("dodge_one_cycle", 32'(DODGE), 0);

    // Hit: player elsewhere during the fall, moves under it for the judgement.
    step_to_row(3'd7, 3'd0);
    do_step(m_col);
    checkOutput("hit_pulse",   32'(HIT),       1);
    checkOutput("hit_nododge", 32'(DODGE),     0);
    checkOutput("hit_visible", 32'(OBJ_VALID), 1);
    checkOutput("hit_row7",    32'(OBJ_ROW),   7);
    next_cycle();
    checkOutput("hit_one_cycle", 32'(HIT), 0);
    for (int i = 0; i < 20; i++) begin
      do_step(3'(i));
      checkOutput("hold_row",   32'(OBJ_ROW),   7);
      checkOutput("hold_valid", 32'(OBJ_VALID), 1);
      checkOutput("hold_hit",   32'(HIT),       0);
    end

    // Abort from HIT_HOLD keeps the count until the next start.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    next_cycle();
    checkOutput("abort_valid",    32'(OBJ_VALID), 0);
    checkOutput("abort_cnt_hold", 32'(DODGE_CNT), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0);
    next_cycle();
    checkOutput("restart_cnt0", 32'(DODGE_CNT), 0);

    // Abort coinciding with a would-be hit on the bottom row.
    dodge_round(seen);
    step_to_row(3'd7, 3'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, m_col);
    next_cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, m_col);
    next_cycle();
    checkOutput("abort_step_hit",   32'(HIT),       0);
    checkOutput("abort_step_dodge", 32'(DODGE),     0);
    checkOutput("abort_step_valid", 32'(OBJ_VALID), 0);
    checkOutput("abort_step_cnt",   32'(DODGE_CNT), 1);
    checkOutput("abort_step_idle",  32'(dut.state == dodge_pkg::IDLE), 1);
    next_cycle();
    checkOutput("abort_after_hit",   32'(HIT),   0);
    checkOutput("abort_after_dodge", 32'(DODGE), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0);
    next_cycle();
    checkOutput("restart2_cnt0", 32'(DODGE_CNT), 0);

    // Drive the dodge count to saturation; probe the first step at SPEEDUP_AT.
    for (int r = 0; r < 300 && m_cnt < 255; r++) begin
      if (m_cnt == SPEEDUP_AT) begin
        do_step(~m_col);
        checkOutput("speedup_first_step", 32'(OBJ_VALID), SPEEDUP_EXPECT);
      end
      dodge_round(seen);
    end
    checkOutput("sat_reach", 32'(DODGE_CNT), 255);
    dodge_round(seen);
    checkOutput("sat_pulse", 32'(DODGE),     1);
    checkOutput("sat_hold",  32'(DODGE_CNT), 255);

    // Reset mid-fall.
    step_to_row(3'd3, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
    next_cycle();
    checkOutput("midrst_valid", 32'(OBJ_VALID), 0);
    checkOutput("midrst_row",   32'(OBJ_ROW),   0);
    checkOutput("midrst_col",   32'(OBJ_COL),   0);
    checkOutput("midrst_cnt",   32'(DODGE_CNT), 0);
    checkOutput("midrst_lfsr",  32'(dut.lfsr),  'hA5);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
